// File: rtl/pipe_if_id_queue.sv
// Fetch-to-decode queue: DEPTH-entry FIFO of {pc4, instruction} pairs
// with valid/ready on both sides, one-cycle branch flush, NOP when empty.
module pipe_if_id_queue #(
    parameter int                 DEPTH     = 4,
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [PC_W-1:0]            if_pc4,
    input  logic [INSTR_W-1:0]         if_instruction,
    output logic                       if_ready,
    input  logic                       is_branch,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [PC_W-1:0]            id_pc4,
    output logic [INSTR_W-1:0]         id_instruction,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PC_W-1:0]    pc_q  [DEPTH];
    logic [INSTR_W-1:0] ins_q [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count_q;
    logic               push;
    logic               pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign if_ready = (count_q < FULL) && !is_branch;
    assign id_valid = (count_q != '0);
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready && !is_branch;
    assign count    = count_q;

    assign id_pc4         = id_valid ? pc_q[rd_ptr]  : '0;
    assign id_instruction = id_valid ? ins_q[rd_ptr] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst || is_branch) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: id_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]  <= if_pc4;
            ins_q[wr_ptr] <= if_instruction;
        end
    end

endmodule

// File: tb/tb_pipe_if_id_queue.sv
// Directed bench for pipe_if_id_queue: DEPTH=4 main instance and a
// DEPTH=3 instance for non-power-of-two wrap streaming.
module tb_pipe_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc4;
    logic [31:0] if_instruction;
    logic        if_ready;
    logic        is_branch;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc4;
    logic [31:0] id_instruction;
    logic [2:0]  count;

    logic        s_if_valid;
    logic [31:0] s_if_pc4;
    logic [31:0] s_if_instruction;
    logic        s_if_ready;
    logic        s_is_branch;
    logic        s_id_ready;
    logic        s_id_valid;
    logic [31:0] s_id_pc4;
    logic [31:0] s_id_instruction;
    logic [1:0]  s_count;

    int checks = 0;
    int passes = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    pipe_if_id_queue #(.DEPTH(4), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc4(if_pc4),
        .if_instruction(if_instruction), .if_ready(if_ready),
        .is_branch(is_branch), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc4(id_pc4),
        .id_instruction(id_instruction), .count(count)
    );

    pipe_if_id_queue #(.DEPTH(3), .NOP_INSTR(NOP)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_valid(s_if_valid), .if_pc4(s_if_pc4),
        .if_instruction(s_if_instruction), .if_ready(s_if_ready),
        .is_branch(s_is_branch), .id_ready(s_id_ready),
        .id_valid(s_id_valid), .id_pc4(s_id_pc4),
        .id_instruction(s_id_instruction), .count(s_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        if_valid       = 1'b1;
        if_pc4         = pc;
        if_instruction = ins;
        step();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b1; if_pc4 = 32'h44;
        if_instruction = 32'h55; id_ready = 1'b0; is_branch = 1'b0;
        s_if_valid = 1'b0; s_id_ready = 1'b0; s_is_branch = 1'b0;
        s_if_pc4 = '0; s_if_instruction = '0;
        step(); step();
        rst = 1'b0; if_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || id_valid !== 1'b0)
            $display("FAIL reset_state count=%0d valid=%b want 0/0", count, id_valid);
        else passes++;
        checks++;
        if (id_instruction !== NOP || id_pc4 !== 32'h0 || if_ready !== 1'b1)
            $display("FAIL reset_out ins=%h pc=%h rdy=%b want %h/0/1",
                     id_instruction, id_pc4, if_ready, NOP);
        else passes++;
        checks++;
        if (s_count !== 2'd0 || s_id_valid !== 1'b0 || s_if_ready !== 1'b1)
            $display("FAIL reset_d3 count=%0d valid=%b rdy=%b want 0/0/1",
                     s_count, s_id_valid, s_if_ready);
        else passes++;
    endtask

    task automatic test_fill_drain();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_ready !== 1'b1)
                $display("FAIL fill_ready[%0d] got %b want 1", i, if_ready);
            else passes++;
            push_one(32'(4 * (i + 1)), 32'hA0 + 32'(i));
        end
        if_valid = 1'b1; if_pc4 = 32'd20; if_instruction = 32'hA4;
        #1;
        checks++;
        if (count !== 3'd4 || if_ready !== 1'b0)
            $display("FAIL full count=%0d rdy=%b want 4/0", count, if_ready);
        else passes++;
        step();
        if_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || id_pc4 !== 32'd4 || id_instruction !== 32'hA0)
            $display("FAIL fifth_offer count=%0d pc=%h ins=%h want 4/4/a0",
                     count, id_pc4, id_instruction);
        else passes++;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc4 !== 32'(4 * (i + 1)) ||
                id_instruction !== 32'hA0 + 32'(i))
                $display("FAIL drain[%0d] v=%b pc=%h ins=%h want 1/%h/%h", i,
                         id_valid, id_pc4, id_instruction,
                         4 * (i + 1), 32'hA0 + 32'(i));
            else passes++;
            step();
        end
        checks++;
        if (id_valid !== 1'b0 || count !== 3'd0 || id_instruction !== NOP ||
            id_pc4 !== 32'h0)
            $display("FAIL drained v=%b count=%0d ins=%h pc=%h want 0/0/nop/0",
                     id_valid, count, id_instruction, id_pc4);
        else passes++;
        id_ready = 1'b0;
    endtask

    task automatic test_stream();
        s_id_ready = 1'b0; s_if_valid = 1'b1;
        s_if_pc4 = 32'h1000; s_if_instruction = 32'hB0;
        step();
        s_id_ready = 1'b1;
        for (int i = 1; i < 10; i++) begin
            s_if_pc4         = 32'h1000 + 32'(4 * i);
            s_if_instruction = 32'hB0 + 32'(i);
            #1;
            checks++;
            if (s_count !== 2'd1 || s_if_ready !== 1'b1 ||
                s_id_pc4 !== 32'h1000 + 32'(4 * (i - 1)) ||
                s_id_instruction !== 32'hB0 + 32'(i - 1))
                $display("FAIL stream[%0d] count=%0d rdy=%b pc=%h ins=%h want 1/1/%h/%h",
                         i, s_count, s_if_ready, s_id_pc4, s_id_instruction,
                         32'h1000 + 32'(4 * (i - 1)), 32'hB0 + 32'(i - 1));
            else passes++;
            step();
        end
        s_if_valid = 1'b0;
        #1;
        checks++;
        if (s_id_pc4 !== 32'h1024 || s_id_instruction !== 32'hB9)
            $display("FAIL stream_last pc=%h ins=%h want 1024/b9",
                     s_id_pc4, s_id_instruction);
        else passes++;
        step();
        checks++;
        if (s_id_valid !== 1'b0 || s_count !== 2'd0)
            $display("FAIL stream_empty v=%b count=%0d want 0/0", s_id_valid, s_count);
        else passes++;
        s_id_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            push_one(32'h10 + 32'(4 * i), 32'hC0 + 32'(i));
        is_branch = 1'b1; if_valid = 1'b1; id_ready = 1'b1;
        if_pc4 = 32'h99; if_instruction = 32'h99;
        #1;
        checks++;
        if (if_ready !== 1'b0)
            $display("FAIL flush_rdy got %b want 0", if_ready);
        else passes++;
        step();
        is_branch = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || id_valid !== 1'b0 || id_pc4 !== 32'h0)
            $display("FAIL flush_state count=%0d v=%b pc=%h want 0/0/0",
                     count, id_valid, id_pc4);
        else passes++;
        push_one(32'h100, 32'hD0);
        checks++;
        if (count !== 3'd1 || id_pc4 !== 32'h100 || id_instruction !== 32'hD0)
            $display("FAIL post_flush count=%0d pc=%h ins=%h want 1/100/d0",
                     count, id_pc4, id_instruction);
        else passes++;
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || count !== 3'd0)
            $display("FAIL post_flush_alone v=%b count=%0d want 0/0", id_valid, count);
        else passes++;
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++)
            push_one(32'h200 + 32'(4 * i), 32'hE0 + 32'(i));
        id_ready = 1'b1; if_valid = 1'b1;
        if_pc4 = 32'h210; if_instruction = 32'hE4;
        #1;
        checks++;
        if (if_ready !== 1'b0)
            $display("FAIL full_pop_rdy got %b want 0", if_ready);
        else passes++;
        step();
        id_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || id_pc4 !== 32'h204 || if_ready !== 1'b1)
            $display("FAIL full_pop count=%0d pc=%h rdy=%b want 3/204/1",
                     count, id_pc4, if_ready);
        else passes++;
        step();
        if_valid = 1'b0;
        checks++;
        if (count !== 3'd4)
            $display("FAIL full_repush count=%0d want 4", count);
        else passes++;
        id_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (id_pc4 !== 32'h200 + 32'(4 * i) || id_instruction !== 32'hE0 + 32'(i))
                $display("FAIL full_drain[%0d] pc=%h ins=%h want %h/%h", i,
                         id_pc4, id_instruction, 32'h200 + 32'(4 * i), 32'hE0 + 32'(i));
            else passes++;
            step();
        end
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0)
            $display("FAIL full_drained v=%b want 0", id_valid);
        else passes++;
    endtask

    task automatic test_reset_mid();
        push_one(32'h300, 32'hF0);
        push_one(32'h304, 32'hF1);
        if_valid = 1'b1; if_pc4 = 32'h308; if_instruction = 32'hF2;
        id_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || id_valid !== 1'b0 || id_instruction !== NOP ||
            id_pc4 !== 32'h0 || if_ready !== 1'b1)
            $display("FAIL reset_mid count=%0d v=%b ins=%h pc=%h rdy=%b want 0/0/nop/0/1",
                     count, id_valid, id_instruction, id_pc4, if_ready);
        else passes++;
        push_one(32'h400, 32'hF8);
        checks++;
        if (count !== 3'd1 || id_pc4 !== 32'h400 || id_instruction !== 32'hF8)
            $display("FAIL reset_mid_push count=%0d pc=%h ins=%h want 1/400/f8",
                     count, id_pc4, id_instruction);
        else passes++;
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0)
            $display("FAIL reset_mid_pop v=%b want 0", id_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_full_pop_push();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
